// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port between two requesters, with I/O port decode.
// Grant is combinational and an access is accepted every cycle; read data returns exactly one cycle after grant.
module data_memory_arbiter #(
  parameter int                ADDR_W        = 10,
  parameter int                DATA_W        = 8,
  parameter logic [ADDR_W-1:0] IN_PORT_ADDR  = 10'h3FE,
  parameter logic [ADDR_W-1:0] OUT_PORT_ADDR = 10'h3FF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] port_in,
  output logic [DATA_W-1:0] port_out
);

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  logic              r_last;
  logic              r_rsp_vld;
  logic              r_rsp_own;
  logic              r_rsp_mem;
  logic [DATA_W-1:0] r_cap;
  logic [DATA_W-1:0] r_port_out;

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_any_gnt;
  logic              w_we;
  logic              w_is_in;
  logic              w_is_out;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  // On contention the requester that did not win last time goes first.
  assign w_a_gnt   = a_req & (~b_req | (r_last == OWN_B));
  assign w_b_gnt   = b_req & (~a_req | (r_last == OWN_A));
  assign w_any_gnt = w_a_gnt | w_b_gnt;

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    if (w_a_gnt) begin
      w_addr  = a_addr;
      w_wdata = a_wdata;
      w_we    = a_we;
    end else if (w_b_gnt) begin
      w_addr  = b_addr;
      w_wdata = b_wdata;
      w_we    = b_we;
    end
  end

  assign w_is_in      = w_any_gnt & (w_addr == IN_PORT_ADDR);
  assign w_is_out     = w_any_gnt & (w_addr == OUT_PORT_ADDR);
  assign mem_addr     = w_addr;
  assign mem_wdata    = w_wdata;
  assign mem_write_en = w_any_gnt & w_we & ~w_is_in & ~w_is_out;
  assign a_gnt        = w_a_gnt;
  assign b_gnt        = w_b_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= OWN_B;
      r_rsp_vld  <= 1'b0;
      r_rsp_own  <= OWN_A;
      r_rsp_mem  <= 1'b0;
      r_cap      <= '0;
      r_port_out <= '0;
    end else begin
      r_rsp_vld <= w_any_gnt & ~w_we;
      if (w_any_gnt) r_last <= w_b_gnt;
      // Port reads are resolved at grant time so the response only needs one data register.
      if (w_any_gnt & ~w_we) begin
        r_rsp_own <= w_b_gnt;
        r_rsp_mem <= ~w_is_in & ~w_is_out;
        r_cap     <= w_is_in ? port_in : r_port_out;
      end
      if (w_any_gnt & w_we & w_is_out) r_port_out <= w_wdata;
    end
  end

  assign w_rdata  = r_rsp_mem ? mem_rdata : r_cap;
  assign a_rvalid = r_rsp_vld & (r_rsp_own == OWN_A);
  assign b_rvalid = r_rsp_vld & (r_rsp_own == OWN_B);
  assign a_rdata  = a_rvalid ? w_rdata : '0;
  assign b_rdata  = b_rvalid ? w_rdata : '0;
  assign port_out = r_port_out;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: behavioural RAM, transaction-level reference model, directed vectors.
module tb_data_memory_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [9:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write_en;
  logic [7:0] a_rdata, b_rdata, mem_wdata, port_out;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] port_in = 8'h00;
  logic [9:0] mem_addr;

  int n_chk = 0;
  int n_pass = 0;

  data_memory_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .port_in(port_in), .port_out(port_out)
  );

  always #5 clk = ~clk;

  // 1024x8 synchronous RAM with registered read
  logic [7:0] ram [0:1023];
  initial for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_write_en) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: which requester won last, one pending response, port register, RAM image.
  bit         m_last_b = 1'b1;
  bit         p_vld = 1'b0;
  bit         p_own_b = 1'b0;
  logic [7:0] p_dat = 8'h00;
  logic [7:0] m_port = 8'h00;
  logic [7:0] m_ram [0:1023];
  initial for (int i = 0; i < 1024; i++) m_ram[i] = 8'h00;

  initial forever begin
    @(negedge rst_n);
    m_last_b = 1'b1; p_vld = 1'b0; p_own_b = 1'b0; p_dat = 8'h00; m_port = 8'h00;
  end

  initial begin : compare
    bit ga, gb, wwe, n_last_b, n_vld, n_own_b, wr;
    logic [9:0] wa;
    logic [7:0] wd, n_dat, n_port;
    forever begin
      @(negedge clk);
      ga = a_req && (!b_req || m_last_b);
      gb = b_req && (!a_req || !m_last_b);
      wa = ga ? a_addr : (gb ? b_addr : 10'h000);
      wd = ga ? a_wdata : (gb ? b_wdata : 8'h00);
      wwe = ga ? a_we : (gb ? b_we : 1'b0);
      chk("a_gnt", a_gnt, ga);
      chk("b_gnt", b_gnt, gb);
      chk("mem_addr", mem_addr, wa);
      chk("mem_wdata", mem_wdata, wd);
      chk("mem_write_en", mem_write_en, (ga || gb) && wwe && wa != 10'h3FE && wa != 10'h3FF);
      chk("a_rvalid", a_rvalid, p_vld && !p_own_b);
      chk("b_rvalid", b_rvalid, p_vld && p_own_b);
      chk("a_rdata", a_rdata, (p_vld && !p_own_b) ? p_dat : 8'h00);
      chk("b_rdata", b_rdata, (p_vld && p_own_b) ? p_dat : 8'h00);
      chk("port_out", port_out, m_port);
      n_last_b = m_last_b; n_vld = 1'b0; n_own_b = p_own_b; n_dat = p_dat; n_port = m_port; wr = 1'b0;
      if (ga || gb) begin
        n_last_b = gb;
        if (wwe) begin
          if (wa == 10'h3FF) n_port = wd;
          else if (wa != 10'h3FE) wr = 1'b1;
        end else begin
          n_vld = 1'b1;
          n_own_b = gb;
          n_dat = (wa == 10'h3FE) ? port_in : ((wa == 10'h3FF) ? m_port : m_ram[wa]);
        end
      end
      @(posedge clk);
      if (rst_n) begin
        m_last_b = n_last_b; p_vld = n_vld; p_own_b = n_own_b; p_dat = n_dat; m_port = n_port;
        if (wr) m_ram[wa] = wd;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic r, input logic w, input logic [9:0] ad, input logic [7:0] d);
    a_req = r; a_we = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [9:0] ad, input logic [7:0] d);
    b_req = r; b_we = w; b_addr = ad; b_wdata = d;
  endtask

  task automatic idle();
    set_a(0, 0, 10'h000, 8'h00);
    set_b(0, 0, 10'h000, 8'h00);
  endtask

  initial begin : stim
    logic exp_v;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_port_out", port_out, 8'h00);
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_mem_we", mem_write_en, 1'b0);
    cyc();
    rst_n = 1'b1;

    // A write then read of normal memory
    set_a(1, 1, 10'h010, 8'h5A);
    @(negedge clk);
    chk("wr_a_gnt", a_gnt, 1'b1);
    chk("wr_mem_we", mem_write_en, 1'b1);
    cyc(); set_a(1, 0, 10'h010, 8'h00);
    @(negedge clk);
    chk("rd_a_gnt", a_gnt, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("rd_a_rvalid", a_rvalid, 1'b1);
    chk("rd_a_rdata", a_rdata, 8'h5A);
    chk("rd_b_rvalid", b_rvalid, 1'b0);

    // B uses the output port
    cyc(); set_b(1, 1, 10'h3FF, 8'hC3);
    @(negedge clk);
    chk("out_wr_mem_we", mem_write_en, 1'b0);
    cyc(); set_b(1, 0, 10'h3FF, 8'h00);
    @(negedge clk);
    chk("out_port_out", port_out, 8'hC3);
    chk("out_rd_mem_we", mem_write_en, 1'b0);
    cyc(); idle();
    @(negedge clk);
    chk("out_b_rvalid", b_rvalid, 1'b1);
    chk("out_b_rdata", b_rdata, 8'hC3);

    // Both requesting continuously: A, B, A, B, A, B
    cyc();
    set_a(1, 0, 10'h010, 8'h00);
    set_b(1, 0, 10'h3FF, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_v = (i % 2 == 0);
      chk("alt_a_gnt", a_gnt, exp_v);
      chk("alt_b_gnt", b_gnt, !exp_v);
      exp_v = (i % 2 == 1);
      chk("alt_a_rvalid", a_rvalid, exp_v);
      chk("alt_a_rdata", a_rdata, exp_v ? 8'h5A : 8'h00);
      exp_v = (i >= 2) && (i % 2 == 0);
      chk("alt_b_rvalid", b_rvalid, exp_v);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("alt_last_b_rdata", b_rdata, 8'hC3);

    // Input port read captures at grant; write to it is ignored
    cyc();
    port_in = 8'h7E;
    set_a(1, 0, 10'h3FE, 8'h00);
    @(negedge clk);
    chk("in_a_gnt", a_gnt, 1'b1);
    cyc();
    port_in = 8'h00;
    set_a(1, 1, 10'h3FE, 8'hFF);
    @(negedge clk);
    chk("in_a_rdata", a_rdata, 8'h7E);
    chk("in_wr_mem_we", mem_write_en, 1'b0);
    cyc(); idle();
    @(negedge clk);
    chk("in_wr_port_out", port_out, 8'hC3);

    // Write then read of the same address on consecutive cycles
    cyc(); set_a(1, 1, 10'h020, 8'h11);
    cyc(); set_a(0, 0, 10'h000, 8'h00); set_b(1, 0, 10'h020, 8'h00);
    @(negedge clk);
    chk("raw_b_gnt", b_gnt, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("raw_b_rdata", b_rdata, 8'h11);

    // Reset with a read outstanding discards the response
    cyc(); set_a(1, 0, 10'h010, 8'h00);
    cyc(); idle();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_a_rvalid", a_rvalid, 1'b0);
    chk("rst2_port_out", port_out, 8'h00);
    cyc();
    set_a(1, 0, 10'h010, 8'h00);
    set_b(1, 0, 10'h020, 8'h00);
    @(negedge clk);
    chk("rst2_first_a", a_gnt, 1'b1);
    chk("rst2_first_b", b_gnt, 1'b0);
    cyc();
    @(negedge clk);
    chk("rst2_second_b", b_gnt, 1'b1);
    chk("rst2_a_rdata", a_rdata, 8'h5A);
    cyc(); idle();
    @(negedge clk);
    chk("rst2_b_rdata", b_rdata, 8'h11);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
